// File: rtl/median_sort_pkg.sv
// Shared constants and helpers for the median_sort_pipe rank-order filter.
package median_sort_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_N      = 9;

  // Widest sample cx can handle; narrower samples are zero-extended by the caller.
  localparam int unsigned CX_W = 64;

  // Compare-exchange: returns {min, max}. Equal operands keep their order.
  function automatic logic [2*CX_W-1:0] cx(input logic [CX_W-1:0] a,
                                          input logic [CX_W-1:0] b);
    return (b < a) ? {b, a} : {a, b};
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/median_sort_pass.sv
// One odd-even transposition layer with its stage register (data, valid, rank).
module median_sort_pass
  import median_sort_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned N      = DEFAULT_N,
  parameter int unsigned PARITY = 0,
  parameter int unsigned RANK_W = clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N*DATA_W-1:0] data_i,
  input  logic                valid_i,
  input  logic [RANK_W-1:0]   rank_i,
  output logic [N*DATA_W-1:0] data_o,
  output logic                valid_o,
  output logic [RANK_W-1:0]   rank_o
);

  logic [N*DATA_W-1:0] data_d, data_q;
  logic                valid_q;
  logic [RANK_W-1:0]   rank_q;

  // Pairs (i, i+1) with i matching PARITY are disjoint, so all read data_i.
  always_comb begin
    data_d = data_i;
    for (int unsigned i = PARITY; i + 1 < N; i += 2) begin
      data_d[i*DATA_W +: DATA_W] = DATA_W'(cx(CX_W'(data_i[i*DATA_W +: DATA_W]),
                                              CX_W'(data_i[(i+1)*DATA_W +: DATA_W])) >> CX_W);
      data_d[(i+1)*DATA_W +: DATA_W] = DATA_W'(cx(CX_W'(data_i[i*DATA_W +: DATA_W]),
                                                  CX_W'(data_i[(i+1)*DATA_W +: DATA_W])));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      rank_q  <= '0;
    end else if (en) begin
      data_q  <= data_d;
      valid_q <= valid_i;
      rank_q  <= rank_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign rank_o  = rank_q;

endmodule

// File: rtl/median_sort_pipe.sv
// Fully pipelined N-input rank-order filter with valid/ready backpressure.
module median_sort_pipe
  import median_sort_pkg::*;
#(
  parameter  int unsigned DATA_W = DEFAULT_DATA_W,
  parameter  int unsigned N      = DEFAULT_N,
  localparam int unsigned RANK_W = clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*DATA_W-1:0] dataIn,
  input  logic [RANK_W-1:0]   rankSel,
  input  logic                inValid,
  output logic                inReady,
  output logic [DATA_W-1:0]   dataOut,
  output logic                rankErr,
  output logic                outValid,
  input  logic                outReady
);

  logic                advance;
  logic [N*DATA_W-1:0] st_data  [N];
  logic                st_valid [N];
  logic [RANK_W-1:0]   st_rank  [N];

  logic [DATA_W-1:0]   dout_d, dout_q;
  logic                err_d, err_q;
  logic                ov_q;
  logic [RANK_W-1:0]   sel;

  assign advance = !ov_q || outReady;
  assign inReady = advance;

  for (genvar k = 0; k < N; k++) begin : g_pass
    if (k == 0) begin : g_first
      median_sort_pass #(
        .DATA_W (DATA_W),
        .N      (N),
        .PARITY (0),
        .RANK_W (RANK_W)
      ) u_pass (
        .clk     (clk),
        .rst     (rst),
        .en      (advance),
        .data_i  (dataIn),
        .valid_i (inValid),
        .rank_i  (rankSel),
        .data_o  (st_data[k]),
        .valid_o (st_valid[k]),
        .rank_o  (st_rank[k])
      );
    end else begin : g_rest
      median_sort_pass #(
        .DATA_W (DATA_W),
        .N      (N),
        .PARITY (k % 2),
        .RANK_W (RANK_W)
      ) u_pass (
        .clk     (clk),
        .rst     (rst),
        .en      (advance),
        .data_i  (st_data[k-1]),
        .valid_i (st_valid[k-1]),
        .rank_i  (st_rank[k-1]),
        .data_o  (st_data[k]),
        .valid_o (st_valid[k]),
        .rank_o  (st_rank[k])
      );
    end
  end

  // Out-of-range ranks saturate to the maximum and flag rankErr.
  always_comb begin
    err_d  = (st_rank[N-1] >= RANK_W'(N));
    sel    = err_d ? RANK_W'(N - 1) : st_rank[N-1];
    dout_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == RANK_W'(i)) dout_d = st_data[N-1][i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q   <= 1'b0;
      dout_q <= '0;
      err_q  <= 1'b0;
    end else if (advance) begin
      ov_q <= st_valid[N-1];
      if (st_valid[N-1]) begin
        dout_q <= dout_d;
        err_q  <= err_d;
      end
    end
  end

  assign outValid = ov_q;
  assign dataOut  = dout_q;
  assign rankErr  = err_q;

endmodule

// File: tb/tb_median_sort_pipe.sv
// Self-checking bench: directed windows, random streaming with backpressure, reset, N=3 variant.
module tb_median_sort_pipe;

  logic clk = 1'b0;
  logic rst;

  logic [71:0] dataIn9;
  logic [3:0]  rank9;
  logic        inValid9, inReady9, outValid9, outReady9, rankErr9;
  logic [7:0]  dataOut9;

  logic [35:0] dataIn3;
  logic [1:0]  rank3;
  logic        inValid3, inReady3, outValid3, outReady3, rankErr3;
  logic [11:0] dataOut3;

  int n_tests = 0;
  int n_fail  = 0;
  int out_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } exp_t;
  exp_t exp_q[$];

  logic [71:0] win [20];
  logic [3:0]  rk  [20];

  always #5 clk = ~clk;

  median_sort_pipe #(.DATA_W(8), .N(9)) u9 (
    .clk(clk), .rst(rst), .dataIn(dataIn9), .rankSel(rank9), .inValid(inValid9),
    .inReady(inReady9), .dataOut(dataOut9), .rankErr(rankErr9), .outValid(outValid9),
    .outReady(outReady9)
  );

  median_sort_pipe #(.DATA_W(12), .N(3)) u3 (
    .clk(clk), .rst(rst), .dataIn(dataIn3), .rankSel(rank3), .inValid(inValid3),
    .inReady(inReady3), .dataOut(dataOut3), .rankErr(rankErr3), .outValid(outValid3),
    .outReady(outReady3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: sort the window, pick the requested order statistic.
  function automatic exp_t ref9(input logic [71:0] w, input logic [3:0] r);
    int   q[$];
    exp_t e;
    for (int i = 0; i < 9; i++) q.push_back(int'(w[i*8 +: 8]));
    q.sort();
    e.e = (r >= 4'd9);
    e.d = e.e ? 8'(q[8]) : 8'(q[r]);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      check("inReady9", 32'(inReady9), 32'(!(outValid9 && !outReady9)));
      if (outValid9 && outReady9) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_out9", 32'(outValid9), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("out9_data", 32'(dataOut9), 32'(e.d));
          check("out9_err", 32'(rankErr9), 32'(e.e));
        end
      end
      if (inValid9 && inReady9) exp_q.push_back(ref9(dataIn9, rank9));
    end
  end

  task automatic send9(input logic [71:0] w, input logic [3:0] r, input logic [7:0] ed,
                       input logic ee, input string tag);
    int lat;
    @(posedge clk); #1;
    dataIn9 = w; rank9 = r; inValid9 = 1'b1; outReady9 = 1'b1;
    check({tag, "_rdy"}, 32'(inReady9), 32'(1));
    @(posedge clk); #1;
    inValid9 = 1'b0;
    lat = 1;
    while (!outValid9 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(10));
    check({tag, "_data"}, 32'(dataOut9), 32'(ed));
    check({tag, "_err"}, 32'(rankErr9), 32'(ee));
  endtask

  task automatic send3(input logic [35:0] w, input logic [1:0] r, input logic [11:0] ed,
                       input logic ee, input string tag);
    int lat;
    @(posedge clk); #1;
    dataIn3 = w; rank3 = r; inValid3 = 1'b1; outReady3 = 1'b1;
    @(posedge clk); #1;
    inValid3 = 1'b0;
    lat = 1;
    while (!outValid3 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(4));
    check({tag, "_data"}, 32'(dataOut3), 32'(ed));
    check({tag, "_err"}, 32'(rankErr3), 32'(ee));
  endtask

  initial begin
    logic [71:0] w;
    logic [71:0] sw;
    int          i;
    int          cyc;
    int          base;
    logic        go;

    rst = 1'b1;
    inValid9 = 1'b0; outReady9 = 1'b1; dataIn9 = '0; rank9 = '0;
    inValid3 = 1'b0; outReady3 = 1'b1; dataIn3 = '0; rank3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_outValid9", 32'(outValid9), 32'(0));
    check("rst_dataOut9", 32'(dataOut9), 32'(0));
    check("rst_rankErr9", 32'(rankErr9), 32'(0));
    check("rst_inReady9", 32'(inReady9), 32'(1));
    check("rst_outValid3", 32'(outValid3), 32'(0));

    w = {8'h21, 8'h44, 8'h7A, 8'h00, 8'h33, 8'h80, 8'hFF, 8'h05, 8'h12};
    send9(w, 4'd4,  8'h33, 1'b0, "median");
    send9(w, 4'd0,  8'h00, 1'b0, "rank0");
    send9(w, 4'd8,  8'hFF, 1'b0, "rank8");
    send9(w, 4'd9,  8'hFF, 1'b1, "rank9");
    send9(w, 4'd15, 8'hFF, 1'b1, "rank15");

    for (int r = 0; r < 16; r += 3)
      send9({9{8'hAA}}, 4'(r), 8'hAA, (r >= 9), "dupAA");
    send9({{5{8'hFF}}, {4{8'h00}}}, 4'd4, 8'hFF, 1'b0, "extremes");

    for (int b = 0; b < 20; b++) begin
      for (int j = 0; j < 9; j++) begin
        if (j > 0 && $urandom_range(0, 3) == 0) sw[j*8 +: 8] = sw[(j-1)*8 +: 8];
        else sw[j*8 +: 8] = 8'($urandom);
      end
      win[b] = sw;
      rk[b]  = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    base = out_cnt;
    i = 0;
    cyc = 0;
    while (i < 20 && cyc < 200) begin
      outReady9 = !(cyc >= 12 && cyc < 15);
      inValid9  = 1'b1;
      dataIn9   = win[i];
      rank9     = rk[i];
      go        = inReady9;
      @(posedge clk); #1;
      if (go) i++;
      cyc++;
    end
    inValid9  = 1'b0;
    outReady9 = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_accepted", 32'(i), 32'(20));
    check("stream_outputs", 32'(out_cnt - base), 32'(20));
    check("stream_empty", 32'(exp_q.size()), 32'(0));

    for (int b = 0; b < 5; b++) begin
      dataIn9 = {$urandom, $urandom, 8'($urandom)};
      rank9 = 4'($urandom_range(0, 8));
      inValid9 = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    dataIn9 = w;
    @(posedge clk); #1;
    rst = 1'b0;
    inValid9 = 1'b0;
    check("midrst_outValid9", 32'(outValid9), 32'(0));
    check("midrst_dataOut9", 32'(dataOut9), 32'(0));
    check("midrst_rankErr9", 32'(rankErr9), 32'(0));
    base = out_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("midrst_no_outputs", 32'(out_cnt - base), 32'(0));
    send9(w, 4'd4, 8'h33, 1'b0, "post_rst");

    send3({12'h800, 12'h001, 12'hFFF}, 2'd1, 12'h800, 1'b0, "n3_rank1");
    send3({12'h800, 12'h001, 12'hFFF}, 2'd3, 12'hFFF, 1'b1, "n3_rank3");
    send3({12'h800, 12'h001, 12'hFFF}, 2'd0, 12'h001, 1'b0, "n3_rank0");
    send3({12'h800, 12'h001, 12'hFFF}, 2'd2, 12'hFFF, 1'b0, "n3_rank2");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/median_sort_pipe.md
# median_sort_pipe

Parametrised, fully pipelined rank-order filter and successor to the fixed 9-input, 8-bit median sorter. It accepts one window of N unsigned samples per cycle and sorts it through an N-pass odd-even transposition network. It returns the sample at a per-beat selectable rank: min, median, max or any order statistic. A valid/ready handshake with backpressure lets it sit between the image line-buffer window generator and downstream filtering stages.

## Interface
- DATA_W, 8, sample width in bits, unsigned, ≥1
- N, 9, samples per window, odd, 3..25
- RANK_W, $clog2(N), width of rank select, derived, not overridden
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- dataIn  in  N*DATA_W  window samples, sample i at [i*DATA_W +: DATA_W]
- rankSel  in  RANK_W  order statistic wanted: 0 = min, (N-1)/2 = median, N-1 = max
- inValid  in  1  dataIn/rankSel valid this cycle
- inReady  out  1  block accepts a beat this cycle
- dataOut  out  DATA_W  selected sample
- rankErr  out  1  rankSel of this beat was ≥ N
- outValid  out  1  dataOut/rankErr valid
- outReady  in  1  downstream accepts dataOut this cycle

## Operation
- One clock; reset is synchronous and active-high.
- advance = !outValid || outReady. inReady = advance, combinational.
- Accept: a beat is taken on an edge where inValid && inReady && !rst.
- Pass k (k = 0..N-1): compare-exchange pairs (i, i+1) with i ≡ k mod 2, i+1 ≤ N-1. Unsigned compare; the smaller value goes to the lower index. Equal values are left in place.
- Pass 0 operates on dataIn. Pass k operates on stage register k-1. Stage register k holds the result of pass k, a valid bit and the carried rankSel.
- After pass N-1 the window is ascending. The output register loads sorted[rankSel]. If rankSel ≥ N, it loads sorted[N-1] and sets rankErr = 1; otherwise rankErr = 0.
- Stall: when advance = 0, every stage register, valid bit and the output register hold their values. Bubbles are not compressed; the valid bit travels with its slot.
- No state machine. The state is the N+1 valid bits plus data.

## Timing
- Reset values: outValid = 0, dataOut = 0, rankErr = 0, all stage valid bits = 0. Stage data is cleared to 0.
- inReady is 1 during reset because outValid = 0. Beats presented while rst = 1 are discarded and never appear.
- Latency: for a beat accepted at edge E with no stall, outValid = 1 and dataOut are valid immediately after edge E+N. For N = 9, this is 10 edges including E.
- Throughput: one beat per cycle while outReady = 1.
- Output handshake: the beat transfers on an edge with outValid && outReady. dataOut, rankErr and outValid are stable while outValid && !outReady.
- A new beat may enter on the same edge that the output beat leaves, because advance = 1.
- Reset mid-operation: all in-flight beats are dropped. outValid is 0 on the cycle after the reset edge.
- Stall of S cycles adds exactly S cycles to the latency of every beat in flight. Beat order is preserved.

## Structure
- Package median_sort_pkg holds:
  - DEFAULT_DATA_W = 8 and DEFAULT_N = 9
  - function cx(a, b) returning {min, max}
  - function clog2 for RANK_W
- Sub-module median_sort_pass, parametrised by DATA_W, N and PARITY. It holds one compare-exchange layer plus its registers: data, valid and rank, with an enable = advance and sync reset.
- The top instantiates N passes with a generate loop, alternating PARITY, and adds the rank-select output register and handshake logic.

## Test plan
- Median of a known window, N = 9, DATA_W = 8, rankSel = 4: dataIn {0x12,0x05,0xFF,0x80,0x33,0x00,0x7A,0x44,0x21} → dataOut = 0x33, rankErr = 0, outValid high exactly 10 edges after accept.
- Rank sweep on the same window with rankSel 0, 8, 9, 15 → dataOut 0x00, 0xFF, 0xFF (rankErr = 1), 0xFF (rankErr = 1).
- Duplicates and extremes:
  - all nine samples 0xAA → 0xAA at every rank
  - window {0,0,0,0,255,255,255,255,255}, rank 4 → 0xFF
- Streaming with backpressure:
  - 20 back-to-back random windows, outReady held low for 3 cycles mid-stream → every output matches the reference-model rank result, in order, with no loss or duplication
  - inReady = 0 exactly while outValid && !outReady
- Reset mid-flight: assert rst for 1 cycle while 5 beats are in the pipe → outValid = 0, dataOut = 0 next cycle, none of the 5 beats ever emerge, and a beat accepted after reset returns normally.
- Parameter variant N = 3, DATA_W = 12:
  - window {0xFFF,0x001,0x800}, rank 1 → 0x800 after 4 edges
  - rank 3 → 0xFFF with rankErr = 1
